// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared types and sizes for the 4-slot TDM demux.
// Optional sync checking: define TDM_DEMUX_SYNC_CHECK_EN.
package tdm_demux_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: 2-bit slot counter, wraps 3->0.
// Clear wins over load-to-1, which wins over increment.
module tdm_slot_ctr
  import tdm_demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (load) begin
      slot <= SLOT_W'(1);
    end else if (inc) begin
      slot <= slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: four-slot TDM demultiplexer with slot-0 sync lock.
// Define TDM_DEMUX_SYNC_CHECK_EN to enable sync_err checking.
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic              sync,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] d,
  output logic              frame_valid,
  output logic              locked,
  output logic [1:0]        slot,
  output logic              sync_err
);

  state_t state, state_n;

  logic [DATA_W-1:0] sbuf [NUM_SLOTS-1];
  logic [NUM_SLOTS-2:0] wr;
  logic clr, load, inc, fire;
  logic [SLOT_W-1:0] ctr;

`ifdef TDM_DEMUX_SYNC_CHECK_EN
  logic err_n;
`endif

  tdm_slot_ctr u_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .load (load),
    .inc  (inc),
    .slot (ctr)
  );

  always_comb begin
    state_n = state;
    clr     = 1'b0;
    load    = 1'b0;
    inc     = 1'b0;
    wr      = '0;
    fire    = 1'b0;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    err_n   = 1'b0;
`endif
    if (en) begin
      unique case (state)
        HUNT: begin
          if (sync) begin
            wr[0]   = 1'b1;
            load    = 1'b1;
            state_n = LOCKED;
          end
        end
        LOCKED: begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
          // early sync restarts the frame; missing sync drops lock
          if (sync && ctr != '0) begin
            err_n = 1'b1;
            wr[0] = 1'b1;
            load  = 1'b1;
          end else if (!sync && ctr == '0) begin
            err_n   = 1'b1;
            clr     = 1'b1;
            state_n = HUNT;
          end else
`endif
          begin
            inc = 1'b1;
            unique case (1'b1)
              ctr == 2'd0: wr[0] = 1'b1;
              ctr == 2'd1: wr[1] = 1'b1;
              ctr == 2'd2: wr[2] = 1'b1;
              ctr == 2'd3: fire  = 1'b1;
            endcase
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      sbuf[0]     <= '0;
      sbuf[1]     <= '0;
      sbuf[2]     <= '0;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      frame_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (wr[0]) sbuf[0] <= din;
      if (wr[1]) sbuf[1] <= din;
      if (wr[2]) sbuf[2] <= din;
      // whole frame lands on one edge
      if (fire) begin
        a <= sbuf[0];
        b <= sbuf[1];
        c <= sbuf[2];
        d <= din;
      end
      frame_valid <= fire;
    end
  end

`ifdef TDM_DEMUX_SYNC_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_err <= 1'b0;
    end else begin
      sync_err <= err_n;
    end
  end
`else
  assign sync_err = 1'b0;
`endif

  assign locked = (state == LOCKED);
  assign slot   = ctr;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: table vectors, hand sequences and a random run
// checked against a frame-level model of the demux.
module tb_tdm_demux4;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          sync = 1'b0;
  logic [DW-1:0] a, b, c, d;
  logic          frame_valid, locked, sync_err;
  logic [1:0]    slot;

  int n_tests = 0;
  int n_fail  = 0;

  tdm_demux4 #(.DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .din         (din),
    .sync        (sync),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .frame_valid (frame_valid),
    .locked      (locked),
    .slot        (slot),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  // frame-level reference model
  bit  m_lock;
  int  m_pos;
  int  m_buf [4];
  int  m_out [4];
  bit  m_fv;
  bit  m_err;

  function automatic void m_reset();
    m_lock = 0;
    m_pos  = 0;
    m_fv   = 0;
    m_err  = 0;
    for (int i = 0; i < 4; i++) begin
      m_buf[i] = 0;
      m_out[i] = 0;
    end
  endfunction

  function automatic void m_beat(bit e, int v, bit s);
    m_fv  = 0;
    m_err = 0;
    if (!e) return;
    if (!m_lock) begin
      if (s) begin
        m_buf[0] = v;
        m_pos    = 1;
        m_lock   = 1;
      end
      return;
    end
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    if (s && m_pos != 0) begin
      m_err    = 1;
      m_buf[0] = v;
      m_pos    = 1;
      return;
    end
    if (!s && m_pos == 0) begin
      m_err  = 1;
      m_lock = 0;
      return;
    end
`endif
    if (m_pos == 3) begin
      m_out[0] = m_buf[0];
      m_out[1] = m_buf[1];
      m_out[2] = m_buf[2];
      m_out[3] = v;
      m_fv     = 1;
    end else begin
      m_buf[m_pos] = v;
    end
    m_pos = (m_pos + 1) % 4;
  endfunction

  task automatic chk(string nm, logic [63:0] got,
                     logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return {44'd0, a, b, c, d};
  endfunction

  function automatic logic [63:0] ctl_vec();
    return {59'd0, frame_valid, locked, slot, sync_err};
  endfunction

  task automatic chk_model(string nm);
    logic [63:0] eo, ec;
    eo = {44'd0, DW'(m_out[0]), DW'(m_out[1]),
          DW'(m_out[2]), DW'(m_out[3])};
    ec = {59'd0, m_fv, m_lock, 2'(m_pos), m_err};
    chk({nm, ".data"}, dut_vec(), eo);
    chk({nm, ".ctl"}, ctl_vec(), ec);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    sync = 1'b0;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic beat(bit e, int v, bit s);
    @(negedge clk);
    en   = e;
    din  = DW'(v);
    sync = s;
    @(posedge clk);
    m_beat(e, v, s);
    #1;
  endtask

  typedef struct {
    bit      rst;
    bit      en;
    int      din;
    bit      sync;
    int      ea, eb, ec, ed;
    bit      efv, elk;
    int      eslot;
  } vec_t;

  vec_t tv [$];

  function automatic vec_t mk(bit r, bit e, int v, bit s,
                              int ea, int eb, int ec, int ed,
                              bit fv, bit lk, int sl);
    vec_t t;
    t.rst = r; t.en = e; t.din = v; t.sync = s;
    t.ea = ea; t.eb = eb; t.ec = ec; t.ed = ed;
    t.efv = fv; t.elk = lk; t.eslot = sl;
    return t;
  endfunction

  initial begin
    logic [63:0] ev;
    bit s;
    bit e;

    // reset state, before any edge is released
    #2;
    chk("reset.data", dut_vec(), 64'd0);
    chk("reset.ctl", ctl_vec(), 64'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    // lock + first frame
    tv.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2));
    tv.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 3));
    tv.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0, 1, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0));
    // hunt discards unsynced beats
    tv.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2));
    tv.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 3));
    tv.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0, 1, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0));

    foreach (tv[i]) begin
      if (tv[i].rst) do_reset();
      beat(tv[i].en, tv[i].din, tv[i].sync);
      ev = {44'd0, DW'(tv[i].ea), DW'(tv[i].eb),
            DW'(tv[i].ec), DW'(tv[i].ed)};
      chk($sformatf("vec%0d.data", i), dut_vec(), ev);
      ev = {59'd0, tv[i].efv, tv[i].elk,
            2'(tv[i].eslot), 1'b0};
      chk($sformatf("vec%0d.ctl", i), ctl_vec(), ev);
    end

    // gapped strobe: slot holds during en=0
    do_reset();
    for (int k = 0; k < 4; k++) begin
      beat(1, 9 + k, k == 0);
      chk("gap.beat", ctl_vec(),
          {59'd0, k == 3, 1'b1, 2'((k + 1) % 4), 1'b0});
      for (int g = 0; g < 3; g++) begin
        beat(0, 15, 1);
        chk("gap.hold", ctl_vec(),
            {59'd0, 1'b0, 1'b1, 2'((k + 1) % 4), 1'b0});
      end
    end
    chk("gap.data", dut_vec(), {44'd0, 16'h9abc});

    // early sync at slot 2
    beat(1, 1, 1);
    beat(1, 2, 0);
    beat(1, 3, 1);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    chk("early.err", {63'd0, sync_err}, 64'd1);
    chk("early.slot", {62'd0, slot}, 64'd1);
`else
    chk("early.err", {63'd0, sync_err}, 64'd0);
    chk("early.slot", {62'd0, slot}, 64'd3);
`endif
    chk_model("early.m0");
    for (int k = 0; k < 3; k++) begin
      beat(1, 4 + k, 0);
      chk_model("early.m");
    end
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    chk("early.frame", dut_vec(), {44'd0, 16'h3456});
`else
    chk("early.frame", dut_vec(), {44'd0, 16'h1234});
`endif

    // missing sync at slot 0
    do_reset();
    for (int k = 0; k < 4; k++) beat(1, 5 + k, k == 0);
    beat(1, 15, 0);
    chk_model("miss.m");
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    chk("miss.ctl", ctl_vec(), {59'd0, 5'b00001});
`else
    chk("miss.ctl", ctl_vec(), {59'd0, 5'b01010});
`endif
    chk("miss.data", dut_vec(), {44'd0, 16'h5678});

    // async reset mid-frame, no clock edge needed
    do_reset();
    for (int k = 0; k < 4; k++) beat(1, 5 + k, k == 0);
    beat(1, 9, 1);
    beat(1, 10, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst.data", dut_vec(), 64'd0);
    chk("arst.ctl", ctl_vec(), 64'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat(1, 12 - k, k == 0);
      chk_model("relock.m");
    end
    chk("relock.data", dut_vec(), {44'd0, 16'hcba9});

    // random run against the model
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      e = ($urandom_range(0, 3) != 0);
      if (m_pos == 0)
        s = ($urandom_range(0, 9) != 0);
      else
        s = ($urandom_range(0, 15) == 0);
      beat(e, int'($urandom_range(0, 15)), s);
      chk_model($sformatf("rand%0d", n));
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-slot time-division demultiplexer: the receive end of the 4:1 select path. It accepts a serialized stream in which slots 0..3 carry channels a..d, locks onto a slot-0 sync marker, and deposits each slot into a per-channel holding register. It publishes all four channels together as one frame. It sits downstream of the `mux4to1` sequencer, or a serial link carrying its output, and feeds channel-parallel consumers.

## Interface
Parameters:
- `DATA_W`, default 1: width of one slot sample and of each channel output.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high; clears all state immediately.
- `en`  in  1  sample strobe; `din`/`sync` are meaningful only when `en`=1.
- `din`  in  DATA_W  slot data.
- `sync`  in  1  marks the current `en` beat as slot 0.
- `a`, `b`, `c`, `d`  out  DATA_W each  registered channel outputs (slots 0..3).
- `frame_valid`  out  1  one-cycle pulse: `a..d` updated with a new complete frame.
- `locked`  out  1  high while in LOCKED.
- `slot`  out  2  index the next `en` beat will be written to.
- `sync_err`  out  1  one-cycle pulse on a framing violation (see Configuration).

## Operation
- States: HUNT, LOCKED. On reset: HUNT, `slot`=0, internal buffers 0, `a..d`=0, `frame_valid`=0, `locked`=0, `sync_err`=0.
- HUNT: beats with `en`=1 and `sync`=0 are discarded. On `en`=1 and `sync`=1: `buf[0]`<=`din`, `slot`<=1, go to LOCKED.
- LOCKED, `en`=1, `slot` in 1..2: `buf[slot]`<=`din`, `slot`<=`slot`+1.
- LOCKED, `en`=1, `slot`=3: `a`<=`buf[0]`, `b`<=`buf[1]`, `c`<=`buf[2]`, `d`<=`din`, all on the same edge. `frame_valid`<=1 for that cycle only. `slot` wraps to 0.
- LOCKED, `en`=1, `slot`=0: `buf[0]`<=`din`, `slot`<=1. Handling of `sync` on this beat is set by Configuration.
- `en`=0: no state change; `slot` and buffers hold.
- `a..d` change only on a `frame_valid` edge and never show a partial frame.
- Slot counter is 2 bits and wraps 3->0 modulo 4. There are no other arithmetic operations.

## Timing
- Latency: last slot (d) sampled at edge N -> `a..d` and `frame_valid`=1 visible after edge N. `frame_valid` returns to 0 after edge N+1 unless another frame completes.
- Minimum frame period is 4 cycles (`en` held high); `frame_valid` may then pulse every 4th cycle.
- `locked` rises after the edge that samples the first sync.
- Reset asserted mid-frame: outputs clear asynchronously. The partial frame is lost and the block re-enters HUNT. Deassertion takes effect at the next edge.
- `sync_err` is registered, asserted for exactly one cycle, and aligned with the offending beat's edge.

## Configuration
- Macro `TDM_DEMUX_SYNC_CHECK_EN`.
- Defined:
  - In LOCKED, `en`=1 with `sync`=1 at `slot`!=0 → `sync_err` pulse, partial frame discarded (no `frame_valid`), `buf[0]`<=`din`, `slot`<=1, stay LOCKED (resync).
  - In LOCKED, `en`=1 with `sync`=0 at `slot`=0 → `sync_err` pulse, beat discarded, go to HUNT, `locked`<=0.
- Undefined: after first lock, `sync` is ignored in LOCKED, the counter free-runs, and `sync_err` is tied to 0.

## Structure
- Package `tdm_demux_pkg`:
  - state enum `{HUNT, LOCKED}`
  - `NUM_SLOTS`=4
  - `SLOT_W`=2
- Sub-module `tdm_slot_ctr` holds the 2-bit wrap counter with load-to-1 and clear. The top level holds the FSM, buffers and output registers.

## Test plan
- Reset then lock, DATA_W=1, `en`=1: beats (`din`,`sync`)=(1,1),(0,0),(1,0),(0,0) → after 4th edge `a`=1,`b`=0,`c`=1,`d`=0, `frame_valid` high exactly 1 cycle, `locked`=1.
- Hunt discard: beats (1,0),(1,0) then the frame above → the first two beats are ignored and the outputs equal 1,0,1,0.
- Gapped strobe: same frame with `en`=0 for 3 cycles between each beat → identical outputs, one `frame_valid`, `slot` holds during the gaps.
- Early sync with macro defined: sync at `slot`=2 → `sync_err` 1 cycle, no `frame_valid`, the next 3 beats complete a frame. With the macro undefined, the same stimulus gives `sync_err`=0 and the frame completes on the counter.
- Missing sync with macro defined: slot-0 beat with `sync`=0 → `sync_err`, `locked`=0; outputs hold the previous frame.
- Async reset asserted between the beats at `slot`=1 and `slot`=2 → `a..d`=0, `locked`=0, `frame_valid`=0 immediately without a clock edge; relock works afterward.
